// File: rtl/mips_core_pkg.sv
// Shared types and default IDs for the memory read arbiter.
// Also provides default ADDR_WIDTH / DATA_WIDTH macros when the build does not set them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam logic [3:0] I_ID_DEFAULT = 4'd0;
    localparam logic [3:0] D_ID_DEFAULT = 4'd1;

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// AXI-style read-address and read-data channel bundles.
// The slave modport is the side that answers a request (drives ARREADY, RDATA/RVALID/RID).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface axi_read_address;
    logic [`ADDR_WIDTH-1:0] araddr;
    logic [3:0]             arlen;
    logic                   arvalid;
    logic                   arready;
    logic [3:0]             arid;

    modport master (output araddr, output arlen, output arvalid, output arid, input arready);
    modport slave  (input araddr, input arlen, input arvalid, input arid, output arready);
endinterface

interface axi_read_data;
    logic [`DATA_WIDTH-1:0] rdata;
    logic                   rvalid;
    logic                   rready;
    logic [3:0]             rid;

    modport master (input rdata, input rvalid, input rid, output rready);
    modport slave  (output rdata, output rvalid, output rid, input rready);
endinterface

// File: rtl/mem_read_arbiter.sv
// Arbitrates i-cache and d-cache refill reads onto one memory read port, one burst at a time.
// Define MEM_READ_ARB_RR_EN for round-robin; otherwise the i-cache has fixed priority.
//
// state | meaning
// IDLE  | no burst in flight; pick a requester and latch its address/length
// ADDR  | present latched request to memory, wait for ARREADY
// DATA  | forward beats to the owner until the beat counter reaches zero
module mem_read_arbiter
    import mips_core_pkg::*;
#(
    parameter int         NUM_BEATS_MAX = 8,
    parameter logic [3:0] I_ID          = I_ID_DEFAULT,
    parameter logic [3:0] D_ID          = D_ID_DEFAULT
) (
    input logic            clk,
    input logic            rst_n,
    axi_read_address.slave i_read_address,
    axi_read_data.slave    i_read_data,
    axi_read_address.slave d_read_address,
    axi_read_data.slave    d_read_data,
    axi_read_address.master mem_read_address,
    axi_read_data.master   mem_read_data
);

    localparam logic [3:0] MAX_LEN = 4'(NUM_BEATS_MAX);

    arb_state_t             state, state_nxt;
    owner_t                 owner, owner_nxt;
    logic [`ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [3:0]             len_q, len_nxt;
    logic [3:0]             cnt_q, cnt_nxt;
    logic                   pick_d;
    logic                   ar_accept;
    logic                   owner_rready;
    logic                   beat;
`ifdef MEM_READ_ARB_RR_EN
    owner_t                 last_q, last_nxt;
`endif

    always_comb begin
        pick_d = 1'b0;
`ifdef MEM_READ_ARB_RR_EN
        // On a tie the requester that did not win last time goes first.
        pick_d = d_read_address.arvalid &&
                 (!i_read_address.arvalid || (last_q == OWNER_I));
`else
        pick_d = d_read_address.arvalid && !i_read_address.arvalid;
`endif
    end

    assign owner_rready = (owner == OWNER_D) ? d_read_data.rready : i_read_data.rready;
    assign ar_accept    = (state == ADDR) && mem_read_address.arready;
    assign beat         = (state == DATA) && mem_read_data.rvalid && owner_rready;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        addr_nxt  = addr_q;
        len_nxt   = len_q;
        cnt_nxt   = cnt_q;
`ifdef MEM_READ_ARB_RR_EN
        last_nxt  = last_q;
`endif
        case (state)
            IDLE: begin
                if (i_read_address.arvalid || d_read_address.arvalid) begin
                    state_nxt = ADDR;
                    if (pick_d) begin
                        owner_nxt = OWNER_D;
                        addr_nxt  = d_read_address.araddr;
                        len_nxt   = clamp_len(d_read_address.arlen, MAX_LEN);
                    end else begin
                        owner_nxt = OWNER_I;
                        addr_nxt  = i_read_address.araddr;
                        len_nxt   = clamp_len(i_read_address.arlen, MAX_LEN);
                    end
                end
            end
            ADDR: begin
                if (ar_accept) begin
                    state_nxt = DATA;
                    // A zero-length request still moves one beat.
                    cnt_nxt   = (len_q == 4'd0) ? 4'd1 : len_q;
`ifdef MEM_READ_ARB_RR_EN
                    last_nxt  = owner;
`endif
                end
            end
            DATA: begin
                if (beat) begin
                    cnt_nxt = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= OWNER_I;
            addr_q <= '0;
            len_q  <= 4'd0;
            cnt_q  <= 4'd0;
`ifdef MEM_READ_ARB_RR_EN
            last_q <= OWNER_D;
`endif
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            addr_q <= addr_nxt;
            len_q  <= len_nxt;
            cnt_q  <= cnt_nxt;
`ifdef MEM_READ_ARB_RR_EN
            last_q <= last_nxt;
`endif
        end
    end

    // Handshake outputs are gated by rst_n so nothing leaks while reset is asserted.
    assign mem_read_address.arvalid = rst_n && (state == ADDR);
    assign mem_read_address.araddr  = addr_q;
    assign mem_read_address.arlen   = len_q;
    assign mem_read_address.arid    = (owner == OWNER_D) ? D_ID : I_ID;

    assign i_read_address.arready = rst_n && ar_accept && (owner == OWNER_I);
    assign d_read_address.arready = rst_n && ar_accept && (owner == OWNER_D);

    assign i_read_data.rdata  = mem_read_data.rdata;
    assign i_read_data.rid    = mem_read_data.rid;
    assign i_read_data.rvalid = rst_n && (state == DATA) && (owner == OWNER_I) &&
                                mem_read_data.rvalid;
    assign d_read_data.rdata  = mem_read_data.rdata;
    assign d_read_data.rid    = mem_read_data.rid;
    assign d_read_data.rvalid = rst_n && (state == DATA) && (owner == OWNER_D) &&
                                mem_read_data.rvalid;

    // Stray beats outside DATA (or during reset) are accepted and discarded.
    assign mem_read_data.rready = (!rst_n || (state != DATA)) ? 1'b1 : owner_rready;

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter NUM_BEATS_MAX, default 8: largest accepted ARLEN; ARLEN above this is clamped to it.
REQ-002 Parameter I_ID, default 4'd0: ARID driven to memory for i-cache grants.
REQ-003 Parameter D_ID, default 4'd1: ARID driven to memory for d-cache grants.
REQ-004 One clock; reset is synchronous and active-low: clk  in  1  clock; rst_n  in  1  synchronous reset, active low.
REQ-005 i_read_address  axi_read_address.slave  ARADDR `ADDR_WIDTH, ARLEN 4, ARVALID/ARREADY 1, ARID 4  i-cache refill request.
REQ-006 i_read_data  axi_read_data.slave  RDATA `DATA_WIDTH, RVALID/RREADY 1, RID 4  i-cache refill data.
REQ-007 d_read_address  axi_read_address.slave  as REQ-005  d-cache refill request.
REQ-008 d_read_data  axi_read_data.slave  as REQ-006  d-cache refill data.
REQ-009 mem_read_address  axi_read_address.master  as REQ-005  shared memory read-address channel.
REQ-010 mem_read_data  axi_read_data.master  as REQ-006  shared memory read-data channel.

Function
REQ-011 States SHALL be IDLE, ADDR, DATA; exactly one read transaction in flight at a time.
REQ-012 IDLE: if any requester ARVALID, latch the winner's ARADDR and clamped ARLEN plus the owner identity, then go to ADDR the next cycle.
REQ-013 ADDR: mem ARVALID=1, ARADDR/ARLEN from the latch, ARID=I_ID or D_ID; on mem ARREADY go to DATA and load the beat counter with ARLEN.
REQ-014 The owner's ARREADY SHALL pulse 1 for exactly the cycle in which mem ARREADY is accepted; a non-owner's ARREADY stays 0.
REQ-015 DATA: RDATA/RID forwarded combinationally to the owner; owner RVALID=mem RVALID; non-owner RVALID=0; mem RREADY=owner RREADY.
REQ-016 Beat counter SHALL decrement on each RVALID&RREADY beat; the beat taking it to 0 returns to IDLE on the next cycle.
REQ-017 ARLEN=0 SHALL be treated as 1 beat.
REQ-018 A requester whose ARVALID is still high after its grant completes is re-arbitrated from IDLE; no back-to-back grant without passing through IDLE (1 idle cycle per transaction).
REQ-019 Simultaneous ARVALID in IDLE: winner chosen per REQ-024/025.
REQ-020 ARVALID deasserting during ADDR SHALL NOT abort the transaction; latched values are used.
REQ-021 An RVALID beat arriving in IDLE or ADDR SHALL be dropped (RREADY=1) and SHALL NOT change the counter.

Reset
REQ-022 With rst_n=0 at a clk edge: state=IDLE, counter=0, owner=i-cache, last-grant=d-cache.
REQ-023 During reset and in the cycle after it, all ARREADY/ARVALID/RVALID outputs SHALL be 0; mid-transaction reset abandons the burst without forwarding further beats.

Configuration
REQ-024 With MEM_READ_ARB_RR_EN defined: round-robin; on a tie the requester not granted last wins; last-grant updates at each accept.
REQ-025 Without MEM_READ_ARB_RR_EN: fixed priority, i-cache always wins ties.

Structure
REQ-026 The state enum and I_ID/D_ID default constants SHALL live in mips_core_pkg; the other localparams stay local.
REQ-027 No sub-module; the arbiter decision is an always_comb block inside the module.

Verification
REQ-028 Single i-cache request ARADDR=0x100, ARLEN=4, mem ARREADY after 2 cycles -> mem ARID=0, i ARREADY pulses once, 4 beats reach i-cache, d RVALID=0, IDLE 1 cycle after the 4th beat.
REQ-029 i and d requests asserted in the same cycle, RR enabled, last=d -> i granted first, then d granted with ARID=1 after i's last beat plus 1 idle cycle.
REQ-030 Same as REQ-029 with the macro undefined and i ARVALID held continuously -> d is never granted while i stays valid.
REQ-031 d request ARLEN=0 -> exactly 1 beat forwarded, return to IDLE.
REQ-032 d request ARLEN=12 with NUM_BEATS_MAX=8 -> mem ARLEN=8, 8 beats forwarded.
REQ-033 rst_n low after beat 2 of 4 -> state IDLE, remaining beats dropped, next i request served normally.
